boolean_function: RTL and testbench

- Evaluates the 4-input Boolean function F(A,B,C,D) = ΠM(0,1,5,8,9,13).
- Used as a gate-level reference function block.
- Primary output F is purely combinational.
- A clocked monitor section adds a registered copy of F, input-combination coverage, and an output transition count.

---
 rtl/boolean_function.sv | 45 ++++
 tb/tb_boolean_function.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/boolean_function.sv
// Reference function block for F(A,B,C,D) = PM(0,1,5,8,9,13) = C | (B & ~D),
// with a clocked monitor: registered F, input-combination coverage and a saturating transition count.
module boolean_function #(
  parameter int unsigned TOG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             F,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             clr,
  output logic             F_q,
  output logic [15:0]      seen,
  output logic             all_seen,
  output logic [TOG_W-1:0] toggles
);

  logic [3:0] idx;

  assign idx      = {A, B, C, D};
  assign F        = C | (B & ~D);
  assign all_seen = (seen == 16'hFFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_q     <= 1'b0;
      seen    <= '0;
      toggles <= '0;
    end else begin
      F_q <= F;
      // clr overrides both coverage accumulation and counting on the same edge
      if (clr) begin
        seen    <= '0;
        toggles <= '0;
      end else begin
        seen <= seen | (16'(1) << idx);
        if ((F != F_q) && (toggles != '1))
          toggles <= toggles + TOG_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_boolean_function.sv
// Self-checking bench for boolean_function: directed sweeps plus random steps against a
// reference model built from the maxterm list and plain integer counters.
module tb_boolean_function;

  logic        clk;
  logic        run;
  logic        rst_n;
  logic        A, B, C, D, clr;
  logic        F, F_q, all_seen;
  logic [15:0] seen;
  logic [7:0]  toggles;
  logic        F2, F_q2, all_seen2;
  logic [15:0] seen2;
  logic [1:0]  toggles2;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic        m_fq;
  logic [15:0] m_seen;
  int          m_tog;
  int          m_tog2;

  boolean_function #(.TOG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .F(F), .A(A), .B(B), .C(C), .D(D), .clr(clr),
    .F_q(F_q), .seen(seen), .all_seen(all_seen), .toggles(toggles)
  );

  boolean_function #(.TOG_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .F(F2), .A(A), .B(B), .C(C), .D(D), .clr(clr),
    .F_q(F_q2), .seen(seen2), .all_seen(all_seen2), .toggles(toggles2)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (run) clk = ~clk;
    end
  end

  // F is 0 exactly on the listed maxterms
  function automatic logic ref_f(input int unsigned i);
    return !(i inside {0, 1, 5, 8, 9, 13});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idx(input int unsigned i);
    {A, B, C, D} = 4'(i);
  endtask

  task automatic model_reset();
    m_fq   = 1'b0;
    m_seen = '0;
    m_tog  = 0;
    m_tog2 = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":F"},        32'(F),        32'(ref_f(int'({A, B, C, D}))));
    chk({tag, ":F_q"},      32'(F_q),      32'(m_fq));
    chk({tag, ":seen"},     32'(seen),     32'(m_seen));
    chk({tag, ":all_seen"}, 32'(all_seen), 32'(m_seen == 16'hFFFF));
    chk({tag, ":toggles"},  32'(toggles),  32'(m_tog));
    chk({tag, ":toggles2"}, 32'(toggles2), 32'(m_tog2));
  endtask

  // drive inputs, check F immediately, take one edge, advance the model, check registers
  task automatic step(input int unsigned i, input logic c, input string tag);
    logic nf;
    set_idx(i);
    clr = c;
    #1;
    chk({tag, ":F_comb"}, 32'(F), 32'(ref_f(i)));
    @(posedge clk);
    nf = ref_f(i);
    if (c) begin
      m_seen = '0;
      m_tog  = 0;
      m_tog2 = 0;
    end else begin
      m_seen = m_seen | (16'(1) << i);
      if (nf != m_fq) begin
        m_tog  = (m_tog  < 255) ? m_tog  + 1 : 255;
        m_tog2 = (m_tog2 < 3)   ? m_tog2 + 1 : 3;
      end
    end
    m_fq = nf;
    #1;
    check_all(tag);
  endtask

  initial begin
    run   = 1'b0;
    rst_n = 1'b0;
    clr   = 1'b0;
    set_idx(0);
    model_reset();
    #3;
    check_all("reset");

    // exhaustive combinational table, clock idle
    for (int unsigned i = 0; i < 16; i++) begin
      set_idx(i);
      #10;
      chk($sformatf("comb_idx%0d", i), 32'(F), 32'(ref_f(i)));
    end

    // boundary pairs on the B & ~D term
    set_idx(4);  #1; chk("pair4",  32'(F), 32'd1);
    set_idx(5);  #1; chk("pair5",  32'(F), 32'd0);
    set_idx(12); #1; chk("pair12", 32'(F), 32'd1);
    set_idx(13); #1; chk("pair13", 32'(F), 32'd0);

    // clocked sweep from reset
    set_idx(0);
    rst_n = 1'b1;
    #2;
    run = 1'b1;
    for (int unsigned i = 0; i < 16; i++) step(i, 1'b0, $sformatf("sweep%0d", i));
    chk("sweep_all_seen", 32'(all_seen), 32'd1);
    chk("sweep_tog16",    32'(toggles),  32'd7);
    step(0, 1'b0, "sweep_wrap");
    chk("sweep_tog17",    32'(toggles),  32'd8);

    // async reset mid-sweep at idx 7
    step(0, 1'b1, "pre_rst_clr");
    for (int unsigned i = 0; i < 8; i++) step(i, 1'b0, $sformatf("mid%0d", i));
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_F_q",     32'(F_q),      32'd0);
    chk("arst_seen",    32'(seen),     32'd0);
    chk("arst_toggles", 32'(toggles),  32'd0);
    chk("arst_allseen", 32'(all_seen), 32'd0);
    chk("arst_F",       32'(F),        32'd1);
    rst_n = 1'b1;

    // clear priority: F_q=0, then clr on an edge with idx 4
    step(0, 1'b0, "clrp_pre");
    chk("clrp_pre_fq", 32'(F_q), 32'd0);
    step(4, 1'b1, "clrp");
    chk("clrp_seen",    32'(seen),    32'd0);
    chk("clrp_toggles", 32'(toggles), 32'd0);
    chk("clrp_F_q",     32'(F_q),     32'd1);
    chk("clrp_F",       32'(F),       32'd1);

    // saturation on the narrow counter
    step(0, 1'b1, "sat_clr");
    for (int unsigned k = 0; k < 10; k++) step((k % 2 == 0) ? 2 : 0, 1'b0, $sformatf("sat%0d", k));
    chk("sat_tog2", 32'(toggles2), 32'd3);
    chk("sat_tog8", 32'(toggles),  32'd10);

    // random steps with occasional clr and async reset
    for (int unsigned k = 0; k < 300; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_arst");
        rst_n = 1'b1;
      end
      step($urandom_range(0, 15), ($urandom_range(0, 15) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
